// File: rtl/tag_fifo.sv
// tag_fifo -- free-list of rename tags for the dispatcher.
//
// Holds every rename tag that is currently free. The dispatcher takes the
// head tag (show-ahead, zero latency) and tags completed on the CDB are
// pushed back. Order is preserved for the tags the list holds.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset (restores identity list)
//   alloc_req    dispatcher consumes the head tag this cycle
//   alloc_tag    head tag, combinational from storage
//   alloc_valid  head tag valid (list not empty)
//   cdb_valid    CDB broadcast valid; returns cdb_tag
//   cdb_tag      tag being returned
//   count        number of free tags held, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
//   ovf_err      sticky: a return was dropped because the list was full
//   unf_err      sticky: alloc_req arrived while empty
//   dup_err      sticky: a return of a tag not currently allocated was
//                rejected (present only with TAG_FIFO_DUP_CHK_EN)
//
// Optional feature macro: TAG_FIFO_DUP_CHK_EN enables an in-use bitmap that
// rejects returns of tags that were never handed out.
//
// DEPTH must equal 2**TAG_W so the pointers wrap naturally.

module tag_fifo #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
`ifdef TAG_FIFO_DUP_CHK_EN
  output logic             unf_err,
  output logic             dup_err
`else
  output logic             unf_err
`endif
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ZERO = '0;
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  logic [TAG_W-1:0] storage_q [DEPTH];
  logic [TAG_W-1:0] storage_d [DEPTH];
  logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             ovf_err_q, ovf_err_d;
  logic             unf_err_q, unf_err_d;

  logic             is_full;
  logic             is_empty;
  logic             pop_ok;
  logic             push_ok;
  logic             return_ok;

`ifdef TAG_FIFO_DUP_CHK_EN
  logic [DEPTH-1:0] in_use_q, in_use_d;
  logic             dup_err_q, dup_err_d;
`endif

  // Status is derived from the occupancy counter only; pointer compare
  // cannot distinguish full from empty when they coincide.
  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == CNT_ZERO);

  assign alloc_tag   = storage_q[rd_ptr_q];
  assign alloc_valid = !is_empty;
  assign count       = count_q;
  assign full        = is_full;
  assign empty       = is_empty;
  assign ovf_err     = ovf_err_q;
  assign unf_err     = unf_err_q;

`ifdef TAG_FIFO_DUP_CHK_EN
  // A return is only legal for a tag that is currently handed out. The
  // check uses the registered bitmap, so a tag popped this same cycle is not
  // yet considered in use.
  assign return_ok = in_use_q[cdb_tag];
  assign dup_err   = dup_err_q;
`else
  assign return_ok = 1'b1;
`endif

  // A pop frees a slot in the same cycle, so a return can be accepted while
  // full if the head is being consumed. When empty the pop is ignored and
  // the pushed tag appears at the head only after the edge (no bypass).
  assign pop_ok  = alloc_req && !is_empty;
  assign push_ok = cdb_valid && return_ok && (!is_full || pop_ok);

  always_comb begin
    storage_d = storage_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_err_d = ovf_err_q;
    unf_err_d = unf_err_q;

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok) begin
      storage_d[wr_ptr_q] = cdb_tag;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end

    if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end

    if (cdb_valid && is_full && !pop_ok) begin
      ovf_err_d = 1'b1;
    end
    if (alloc_req && is_empty) begin
      unf_err_d = 1'b1;
    end
  end

`ifdef TAG_FIFO_DUP_CHK_EN
  // Set on dispatch, cleared on an accepted return; the clear is applied
  // last so it wins when the same tag is popped and returned together.
  always_comb begin
    in_use_d  = in_use_q;
    dup_err_d = dup_err_q;
    if (pop_ok) begin
      in_use_d[storage_q[rd_ptr_q]] = 1'b1;
    end
    if (push_ok) begin
      in_use_d[cdb_tag] = 1'b0;
    end
    if (cdb_valid && !return_ok) begin
      dup_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use_q  <= '0;
      dup_err_q <= 1'b0;
    end else begin
      in_use_q  <= in_use_d;
      dup_err_q <= dup_err_d;
    end
  end
`endif

  // Reset reloads the identity list: every tag is free and the head is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= TAG_W'(i);
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= FULL_CNT;
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      storage_q <= storage_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

endmodule

// File: doc/tag_fifo.md
Name: tag_fifo

Overview:
- Free-list of rename tags for the dispatcher; sits directly upstream of the register status table.
- On dispatch it supplies the next free 6-bit tag. The dispatcher writes that tag, with its valid bit set, into the status table entry for RD.
- When the CDB broadcasts a completed tag, that tag returns to the free-list for reuse.
- Circular buffer with show-ahead head, occupancy counter, and sticky error flags.

Parameters:
- TAG_W, 6, tag width in bits; must match the CDB tag width.
- DEPTH, 64, number of tags managed; must equal 2**TAG_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- alloc_req  input  1  dispatcher consumes the head tag this cycle.
- alloc_tag  output  TAG_W  current head tag (show-ahead), combinational from storage.
- alloc_valid  output  1  head tag is valid (FIFO not empty).
- cdb_valid  input  1  CDB broadcast valid; returns a tag.
- cdb_tag  input  TAG_W  tag being returned.
- count  output  TAG_W+1  number of free tags held, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf_err  output  1  sticky: a return was dropped because the FIFO was full.
- unf_err  output  1  sticky: alloc_req arrived while empty.

Behaviour:
- Reset is asynchronous and active-high. Every tag is free at reset.
  - storage[i] = i for i = 0..DEPTH-1; rd_ptr = 0; wr_ptr = 0.
  - count = DEPTH; full = 1; empty = 0; alloc_valid = 1; alloc_tag = 0; ovf_err = 0; unf_err = 0.
- alloc_tag = storage[rd_ptr] and alloc_valid = !empty, both combinational. The tag is usable in the same cycle alloc_req is asserted, with zero latency.
- Pop: accepted when alloc_req && !empty.
  - rd_ptr increments modulo DEPTH at the next edge.
  - alloc_req && empty: ignored (pointers and count unchanged); unf_err set.
- Push: accepted when cdb_valid && (!full || pop accepted this cycle).
  - storage[wr_ptr] <= cdb_tag; wr_ptr increments modulo DEPTH.
  - cdb_valid with full and no pop: tag dropped, ovf_err set.
- Count update:
  - pop only: count - 1.
  - push only: count + 1.
  - both or neither: count unchanged.
- Simultaneous push and pop:
  - When empty: the push is accepted and the pop is ignored. The returned tag becomes visible on alloc_tag in the next cycle, not the same cycle (no bypass).
  - When full: both are accepted and count stays at DEPTH.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. full and empty derive from count only, never from pointer compare.
- full, empty and count are registered-derived and change only at clock edges (or at reset).
- ovf_err and unf_err stay set until rst.
- Reset mid-operation restores the full identity list immediately; any in-flight dispatch or return in that cycle is discarded.
- There is no ordering requirement on returned tags; the FIFO is order-preserving for the tags it holds.

Optional Feature:
- Macro: TAG_FIFO_DUP_CHK_EN.
- When defined:
  - Keep a DEPTH-bit in_use bitmap, cleared at reset.
  - An accepted pop sets in_use[alloc_tag].
  - A return with in_use[cdb_tag] == 0 is rejected: not pushed, and sticky output dup_err (1 bit, reset 0) is set.
  - An accepted push clears in_use[cdb_tag].
  - If a pop and a push of the same tag occur in one cycle, the clear takes priority after the check.
- When not defined:
  - No bitmap; every cdb_valid return is pushed subject only to the full rule.
  - The dup_err port is absent.

Test Plan:
- Reset, then alloc_req high for 3 cycles -> alloc_tag shows 0,1,2 in those cycles; count = 61; full = 0 after the first edge.
- Pop all 64 tags, then alloc_req again -> empty = 1, alloc_valid = 0, count = 0, unf_err = 1, pointers unchanged.
- From empty, cdb_valid with cdb_tag = 37 and alloc_req high in the same cycle -> push accepted, pop ignored; next cycle alloc_tag = 37, count = 1.
- From reset (full), cdb_valid with tag 5 and no alloc_req -> tag dropped, ovf_err = 1, count = 64. Repeat with alloc_req high -> count stays 64, no new error.
- Pop 64 tags, return 64 tags in order 63..0, then pop 2 -> alloc_tag = 63, then 62 (pointer wrap verified).
- With TAG_FIFO_DUP_CHK_EN defined: from reset, return tag 9 without popping it; with alloc_req high that cycle so full does not block -> dup_err = 1, count decrements by 1 only (push rejected).
